// File: rtl/power_sequencer.sv
// Power-rail sequencer for a voltage monitor: timed start-up, settle qualification,
// bounded automatic retries after faults, and a lockout that only cmd_clear releases.
module power_sequencer #(
  parameter int STARTUP_CYCLES = 2500000,
  parameter int SETTLE_CYCLES  = 500000,
  parameter int RETRY_CYCLES   = 25000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_on,
  input  logic       cmd_off,
  input  logic       cmd_clear,
  input  logic       pm_error,
  output logic       pm_start,
  output logic       power_good,
  output logic       fault_lockout,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_DELAY      = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_ON         = 3'd3,
    ST_RETRY_WAIT = 3'd4,
    ST_LOCKOUT    = 3'd5
  } state_t;

  localparam logic [25:0] STARTUP_LOAD = 26'(STARTUP_CYCLES - 1);
  localparam logic [25:0] SETTLE_LOAD  = 26'(SETTLE_CYCLES - 1);
  localparam logic [25:0] RETRY_LOAD   = 26'(RETRY_CYCLES - 1);
  localparam logic [3:0]  MAX_RETRY    = 4'(MAX_RETRIES);

  logic [1:0]  rst_sync_r;
  logic        rst_n_s;
  state_t      state_r;
  state_t      state_s;
  logic [25:0] cnt_r;
  logic [25:0] cnt_s;
  logic [3:0]  retry_r;
  logic [3:0]  retry_s;
  state_t      fault_state_s;
  logic [25:0] fault_cnt_s;
  logic [3:0]  fault_retry_s;
  logic        pm_start_r;
  logic        power_good_r;
  logic        fault_lockout_r;

  // Reset assertion is immediate; release is delayed by two clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Destination of a monitor fault: another retry if budget remains, else lockout.
  always_comb begin
    fault_state_s = ST_LOCKOUT;
    fault_cnt_s   = 26'd0;
    fault_retry_s = retry_r;
    if (retry_r < MAX_RETRY) begin
      fault_state_s = ST_RETRY_WAIT;
      fault_cnt_s   = RETRY_LOAD;
      fault_retry_s = retry_r + 4'd1;
    end else begin
      fault_state_s = ST_LOCKOUT;
      fault_cnt_s   = 26'd0;
      fault_retry_s = retry_r;
    end
  end

  // Next-state logic; cmd_off outranks faults and timer expiry in every active state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    retry_s = retry_r;
    case (state_r)
      ST_OFF: begin
        cnt_s   = 26'd0;
        retry_s = 4'd0;
        if (cmd_on && !cmd_off) begin
          state_s = ST_DELAY;
          cnt_s   = STARTUP_LOAD;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_DELAY: begin
        if (cmd_off) begin
          state_s = ST_OFF;
          cnt_s   = 26'd0;
          retry_s = 4'd0;
        end else if (cnt_r == 26'd0) begin
          state_s = ST_SETTLE;
          cnt_s   = SETTLE_LOAD;
        end else begin
          cnt_s = cnt_r - 26'd1;
        end
      end
      ST_SETTLE: begin
        if (cmd_off) begin
          state_s = ST_OFF;
          cnt_s   = 26'd0;
          retry_s = 4'd0;
        end else if (pm_error) begin
          state_s = fault_state_s;
          cnt_s   = fault_cnt_s;
          retry_s = fault_retry_s;
        end else if (cnt_r == 26'd0) begin
          state_s = ST_ON;
          cnt_s   = 26'd0;
        end else begin
          cnt_s = cnt_r - 26'd1;
        end
      end
      ST_ON: begin
        if (cmd_off) begin
          state_s = ST_OFF;
          cnt_s   = 26'd0;
          retry_s = 4'd0;
        end else if (pm_error) begin
          state_s = fault_state_s;
          cnt_s   = fault_cnt_s;
          retry_s = fault_retry_s;
        end else begin
          state_s = ST_ON;
        end
      end
      ST_RETRY_WAIT: begin
        if (cmd_off) begin
          state_s = ST_OFF;
          cnt_s   = 26'd0;
          retry_s = 4'd0;
        end else if (cnt_r == 26'd0) begin
          state_s = ST_SETTLE;
          cnt_s   = SETTLE_LOAD;
        end else begin
          cnt_s = cnt_r - 26'd1;
        end
      end
      ST_LOCKOUT: begin
        cnt_s = 26'd0;
        if (cmd_clear) begin
          state_s = ST_OFF;
          retry_s = 4'd0;
        end else begin
          state_s = ST_LOCKOUT;
        end
      end
      default: begin
        state_s = ST_OFF;
        cnt_s   = 26'd0;
        retry_s = 4'd0;
      end
    endcase
  end

  // State, timer and outputs all update together; outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r         <= ST_OFF;
      cnt_r           <= 26'd0;
      retry_r         <= 4'd0;
      pm_start_r      <= 1'b0;
      power_good_r    <= 1'b0;
      fault_lockout_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      retry_r         <= retry_s;
      pm_start_r      <= (state_s == ST_SETTLE) || (state_s == ST_ON);
      power_good_r    <= (state_s == ST_ON);
      fault_lockout_r <= (state_s == ST_LOCKOUT);
    end
  end

  assign state         = state_r;
  assign retry_cnt     = retry_r;
  assign pm_start      = pm_start_r;
  assign power_good    = power_good_r;
  assign fault_lockout = fault_lockout_r;

endmodule
